mdio_master: RTL and testbench

//  Clause-22 MDIO management master. Takes read/write commands over a valid/ready port and

---
 rtl/mdio_master.sv | 96 +++++++++
 tb/tb_mdio_master.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO master with MDC divider; MDIO_PREAMBLE_SUPPRESS_EN adds cmd_no_preamble
module mdio_master #(
   parameter int CLK_DIV = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  cmd_opcode,
   input  logic [4:0]  cmd_phy_addr,
   input  logic [4:0]  cmd_reg_addr,
   input  logic [15:0] cmd_data,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_valid,
   output logic        busy,
   output logic        mdc_o,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        mdio_i
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   ,
   input  logic        cmd_no_preamble
`endif
);
   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA} state_t;
   state_t state, st_nxt;
   logic [DW-1:0] div;
   logic [5:0] bit_cnt, bit_nxt;
   logic [63:0] tx;
   logic [15:0] rx;
   logic rd, cmd_ok, no_pre;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   assign no_pre = cmd_no_preamble;
`else
   assign no_pre = 1'b0;
`endif
   assign cmd_ok = cmd_valid && cmd_ready && (cmd_opcode == 2'b01 || cmd_opcode == 2'b10);
   assign bit_nxt = bit_cnt + 6'd1;
   assign st_nxt = bit_nxt < 6'd32 ? PRE : bit_nxt < 6'd46 ? HDR : bit_nxt < 6'd48 ? TA : DATA;
   // frame bit b lives at tx[63-b], i.e. tx[~b] for a 6-bit index
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         div <= '0;
         bit_cnt <= '0;
         tx <= '0;
         rx <= '0;
         rd <= 1'b0;
         cmd_ready <= 1'b1;
         busy <= 1'b0;
         mdc_o <= 1'b0;
         mdio_o <= 1'b1;
         mdio_oe <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data <= '0;
      end else begin
         rsp_valid <= 1'b0;
         if (state == IDLE) begin
            if (cmd_ok) begin
               tx <= {32'hFFFF_FFFF, 2'b01, cmd_opcode, cmd_phy_addr, cmd_reg_addr, 2'b10, cmd_data};
               rd <= cmd_opcode == 2'b10;
               bit_cnt <= no_pre ? 6'd32 : 6'd0;
               div <= '0;
               state <= no_pre ? HDR : PRE;
               busy <= 1'b1;
               cmd_ready <= 1'b0;
               mdio_o <= ~no_pre;
               mdio_oe <= 1'b1;
            end
         end else if (div != DW'(CLK_DIV - 1)) begin
            div <= div + 1'b1;
         end else begin
            div <= '0;
            mdc_o <= ~mdc_o;
            if (mdc_o) begin
               if (state == DATA) rx <= {rx[14:0], mdio_i};
               if (bit_cnt == 6'd63) begin
                  state <= IDLE;
                  busy <= 1'b0;
                  cmd_ready <= 1'b1;
                  mdio_o <= 1'b1;
                  mdio_oe <= 1'b0;
                  rsp_valid <= rd;
                  if (rd) rsp_data <= {rx[14:0], mdio_i};
               end else begin
                  bit_cnt <= bit_nxt;
                  state <= st_nxt;
                  mdio_o <= tx[~bit_nxt];
                  mdio_oe <= !rd || bit_nxt < 6'd46;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: table-driven MDIO master bench with PHY read model and response scoreboard
module tb_mdio_master;
   localparam int CLK_DIV = 4;
   logic clk = 1'b0, rst = 1'b1;
   logic [1:0] cmd_opcode = '0;
   logic [4:0] cmd_phy_addr = '0, cmd_reg_addr = '0;
   logic [15:0] cmd_data = '0, rsp_data;
   logic cmd_valid = 1'b0, cmd_ready, rsp_valid, busy, mdc_o, mdio_o, mdio_oe;
   logic mdio_i = 1'b1;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   logic cmd_no_preamble = 1'b0;
`endif
   mdio_master #(.CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .rst(rst), .cmd_opcode(cmd_opcode), .cmd_phy_addr(cmd_phy_addr),
      .cmd_reg_addr(cmd_reg_addr), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid), .busy(busy),
      .mdc_o(mdc_o), .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i)
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      , .cmd_no_preamble(cmd_no_preamble)
`endif
   );
   always #5 clk = ~clk;
   typedef struct {logic [1:0] op; logic [4:0] pa; logic [4:0] ra; logic [15:0] wd; logic [15:0] ret; logic np;} vec_t;
   typedef struct {logic [15:0] d; int t;} exp_t;
   exp_t sb[$];
   vec_t tbl[5];
   int checks = 0, failures = 0, cyc = 0;
   int t_acc = 0, cur_len = 64, ncap = 0, first_rise = 0;
   int phy_t = 0, phy_start = 0;
   logic [15:0] phy_word = '0;
   logic [63:0] cap = '0, oe_cap = '0;
   logic mdc_q = 1'b0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   always @(posedge clk) cyc <= cyc + 1;
   // PHY model: drives read data bits 48..63 from the accept time
   always @(negedge clk) begin
      int b;
      b = phy_start + (cyc - phy_t - 1) / (2 * CLK_DIV);
      mdio_i = (cyc > phy_t && b >= 48 && b <= 63) ? phy_word[63 - b] : 1'b1;
   end
   always @(negedge clk) begin
      if (mdc_o && !mdc_q) begin
         if (ncap == 0) first_rise = cyc;
         cap = {cap[62:0], mdio_o};
         oe_cap = {oe_cap[62:0], mdio_oe};
         ncap++;
      end
      mdc_q = mdc_o;
   end
   always @(negedge clk) begin
      if (rsp_valid) begin
         if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_data", rsp_data, e.d);
            chk("rsp_time", cyc, e.t);
         end
      end
   end
   task automatic issue(input vec_t v, input bit expect_rsp);
      int n;
      @(negedge clk);
      cmd_opcode = v.op; cmd_phy_addr = v.pa; cmd_reg_addr = v.ra; cmd_data = v.wd;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      cmd_no_preamble = v.np;
`endif
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
      chk("busy_at_accept", busy, 0);
      t_acc = cyc; cap = '0; oe_cap = '0; ncap = 0;
      phy_start = v.np ? 32 : 0;
      cur_len = 64 - phy_start;
      phy_word = v.ret; phy_t = cyc;
      if (v.op == 2'b10 && expect_rsp) sb.push_back('{v.ret, cyc + 1 + cur_len * 2 * CLK_DIV});
      @(posedge clk); #1 cmd_valid = 1'b0;
      chk("busy_after_accept", busy, 1);
      chk("ready_after_accept", cmd_ready, 0);
   endtask
   task automatic wait_done();
      int n;
      n = 0;
      while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
      chk("ready_return_time", cyc, t_acc + 1 + cur_len * 2 * CLK_DIV);
      chk("idle_outputs", {mdc_o, mdio_oe, mdio_o, busy}, 4'b0010);
      repeat (2) @(negedge clk);
   endtask
   task automatic run(input vec_t v);
      logic [63:0] frame, m, oe_e;
      issue(v, 1'b1);
      wait_done();
      frame = {32'hFFFF_FFFF, 2'b01, v.op, v.pa, v.ra, 2'b10, v.wd};
      m = cur_len == 64 ? '1 : (64'd1 << cur_len) - 64'd1;
      oe_e = v.op == 2'b10 ? 64'hFFFF_FFFF_FFFC_0000 : '1;
      chk("mdc_bits", ncap, cur_len);
      chk("first_mdc_rise", first_rise, t_acc + 1 + CLK_DIV);
      chk("mdio_stream", cap & m & oe_e, frame & m & oe_e);
      chk("mdio_oe", oe_cap & m, oe_e & m);
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
   initial begin
      vec_t v;
      tbl[0] = '{2'b01, 5'h01, 5'h00, 16'h1140, 16'h0000, 1'b0};
      tbl[1] = '{2'b10, 5'h1F, 5'h02, 16'h0000, 16'h0141, 1'b0};
      tbl[2] = '{2'b01, 5'h0A, 5'h1F, 16'hA5C3, 16'h0000, 1'b0};
      tbl[3] = '{2'b10, 5'h03, 5'h11, 16'h1234, 16'h8001, 1'b0};
      tbl[4] = '{2'b10, 5'h15, 5'h0A, 16'hFFFF, 16'h0000, 1'b0};
      repeat (3) @(negedge clk);
      chk("reset_outputs", {cmd_ready, busy, mdc_o, mdio_o, mdio_oe, rsp_valid}, 6'b100100);
      chk("reset_rsp_data", rsp_data, 16'h0000);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         run(tbl[i]);
         if (i == 0) chk("t1_stream_literal", cap[31:0], 32'h5082_1140);
         if (i == 1) chk("t2_rsp_data_held", rsp_data, 16'h0141);
      end
      // invalid opcodes are dropped without touching MDC
      @(negedge clk);
      cmd_opcode = 2'b00; cmd_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i == 6) cmd_opcode = 2'b11;
         @(negedge clk);
         chk("invalid_op_idle", {mdc_o, cmd_ready, busy}, 3'b010);
      end
      cmd_valid = 1'b0;
      // back-to-back reads: second accepted exactly when ready returns
      begin
         int t1;
         v = '{2'b10, 5'h02, 5'h03, 16'h0000, 16'hC0DE, 1'b0};
         issue(v, 1'b1);
         t1 = t_acc;
         v = '{2'b10, 5'h04, 5'h05, 16'h0000, 16'h5A5A, 1'b0};
         issue(v, 1'b1);
         chk("b2b_accept_time", t_acc, t1 + 1 + 128 * CLK_DIV);
         wait_done();
      end
      // reset during bit 40 of a read aborts with no response
      v = '{2'b10, 5'h07, 5'h08, 16'h0000, 16'hFACE, 1'b0};
      issue(v, 1'b0);
      while (cyc < t_acc + 1 + 40 * 2 * CLK_DIV + 3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_outputs", {mdc_o, mdio_oe, mdio_o, cmd_ready, busy, rsp_valid}, 6'b001100);
      rst = 1'b0;
      repeat (600) @(negedge clk);
      chk("abort_stays_idle", {cmd_ready, busy, mdc_o}, 3'b100);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
      v = '{2'b10, 5'h09, 5'h0C, 16'h0000, 16'hBEEF, 1'b1};
      run(v);
      chk("np_first_bit_st0", cap[31], 1'b0);
      chk("np_rsp_data", rsp_data, 16'hBEEF);
`endif
      repeat (10) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
